qed_dup_injector: RTL and testbench

SQED instruction injector that sits between the free instruction source and the RIDECORE fetch path.
- Sanitises each incoming instruction into an "original" that touches only registers x0–x15, issues it, and queues it.
- Later replays every queued instruction as a "duplicate" remapped onto x16–x31.
- It produces the original/duplicate stream whose commit counts and register-pair equality are checked downstream at the architectural register file.

---
 rtl/qed_dup_injector.sv | 133 +++++++++++++
 tb/tb_qed_dup_injector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/qed_dup_injector.sv
// SQED duplicate injector: issues sanitised originals on x0-x15, queues them,
// then replays each one remapped onto x16-x31 so the two halves can be compared.
module qed_dup_injector #(
  parameter int QUEUE_DEPTH = 8,
  parameter int QADDR       = 3
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic [31:0]      ifu_instruction,
  input  logic             qed_exec_dup,
  input  logic             ifu_stall,
  output logic [31:0]      qed_instruction,
  output logic             qed_vld_out,
  output logic             qed_mode,
  output logic [15:0]      num_orig_issued,
  output logic [15:0]      num_dup_issued,
  output logic [QADDR:0]   queue_count
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP   = 7'b0110011;
  localparam logic [6:0]  OPC_IMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LUI  = 7'b0110111;
  localparam logic [QADDR:0] FULL  = (QADDR+1)'(QUEUE_DEPTH);

  typedef enum logic {ORIG = 1'b0, DUP = 1'b1} state_t;

  state_t             state, state_nx;
  logic [31:0]        mem [QUEUE_DEPTH];
  logic [QADDR-1:0]   head, tail;
  logic [QADDR:0]     count_nx;
  logic [31:0]        orig_ins, dup_ins;
  logic               push, pop;

  // Originals only touch x0-x15; an original whose rd collapses to x0 has no
  // architectural effect, so it is issued as a plain NOP and never duplicated.
  function automatic logic [31:0] sanitise(input logic [31:0] i);
    logic [31:0] r;
    r = i;
    case (i[6:0])
      OPC_OP:  begin r[24] = 1'b0; r[19] = 1'b0; r[11] = 1'b0; end
      OPC_IMM: begin r[19] = 1'b0; r[11] = 1'b0; end
      OPC_LUI: r[11] = 1'b0;
      default: r = NOP;
    endcase
    if (r[11:7] == 5'd0) r = NOP;
    return r;
  endfunction

  function automatic logic [4:0] hi_reg(input logic [4:0] f);
    return (f == 5'd0) ? 5'd0 : (f | 5'b10000);
  endfunction

  function automatic logic [31:0] remap(input logic [31:0] i);
    logic [31:0] r;
    r = i;
    case (i[6:0])
      OPC_OP: begin
        r[24:20] = hi_reg(i[24:20]);
        r[19:15] = hi_reg(i[19:15]);
        r[11:7]  = hi_reg(i[11:7]);
      end
      OPC_IMM: begin
        r[19:15] = hi_reg(i[19:15]);
        r[11:7]  = hi_reg(i[11:7]);
      end
      OPC_LUI: r[11:7] = hi_reg(i[11:7]);
      default: r = i;
    endcase
    return r;
  endfunction

  always_comb begin
    orig_ins = sanitise(ifu_instruction);
    dup_ins  = remap(mem[head]);
    push     = 1'b0;
    pop      = 1'b0;
    count_nx = queue_count;
    state_nx = state;
    if (!ifu_stall) begin
      case (state)
        ORIG: begin
          push     = (orig_ins[11:7] != 5'd0);
          count_nx = queue_count + (QADDR+1)'(push);
          if (count_nx == FULL || (qed_exec_dup && count_nx != '0))
            state_nx = DUP;
        end
        DUP: begin
          pop      = 1'b1;
          count_nx = queue_count - (QADDR+1)'(1);
          if (count_nx == '0)
            state_nx = ORIG;
        end
        default: state_nx = ORIG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state           <= ORIG;
      head            <= '0;
      tail            <= '0;
      queue_count     <= '0;
      num_orig_issued <= '0;
      num_dup_issued  <= '0;
      qed_instruction <= NOP;
      qed_vld_out     <= 1'b0;
    end else if (!ifu_stall) begin
      state           <= state_nx;
      queue_count     <= count_nx;
      qed_vld_out     <= 1'b1;
      qed_instruction <= (state == DUP) ? dup_ins : orig_ins;
      if (push) begin
        tail            <= tail + QADDR'(1);
        num_orig_issued <= num_orig_issued + 16'd1;
      end
      if (pop) begin
        head           <= head + QADDR'(1);
        num_dup_issued <= num_dup_issued + 16'd1;
      end
    end
  end

  // Queue storage carries no reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (!ifu_stall && push)
      mem[tail] <= orig_ins;
  end

  assign qed_mode = state;

endmodule

// File: tb/tb_qed_dup_injector.sv
// Bench for qed_dup_injector: a vector table for the single-cycle behaviour,
// then scoreboarded sequences for queue fill, stalls in DUP and reset mid-DUP.
module tb_qed_dup_injector;

  logic        clk = 1'b0;
  logic        reset_x;
  logic [31:0] ifu_instruction;
  logic        qed_exec_dup;
  logic        ifu_stall;
  logic [31:0] qed_instruction;
  logic        qed_vld_out;
  logic        qed_mode;
  logic [15:0] num_orig_issued;
  logic [15:0] num_dup_issued;
  logic [3:0]  queue_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int exp_orig = 0;
  int exp_dup  = 0;

  qed_dup_injector #(.QUEUE_DEPTH(8), .QADDR(3)) dut (
    .clk(clk), .reset_x(reset_x), .ifu_instruction(ifu_instruction),
    .qed_exec_dup(qed_exec_dup), .ifu_stall(ifu_stall),
    .qed_instruction(qed_instruction), .qed_vld_out(qed_vld_out),
    .qed_mode(qed_mode), .num_orig_issued(num_orig_issued),
    .num_dup_issued(num_dup_issued), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        exec;
    logic        stall;
    logic [31:0] e_ins;
    logic        e_mode;
    logic [15:0] e_orig;
    logic [15:0] e_dup;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic mode, input int o, input int d,
                           input int cnt);
    chk({tag, " mode"}, 32'(qed_mode), 32'(mode));
    chk({tag, " orig"}, 32'(num_orig_issued), 32'(o));
    chk({tag, " dup"},  32'(num_dup_issued), 32'(d));
    chk({tag, " cnt"},  32'(queue_count), 32'(cnt));
  endtask

  task automatic drive(input logic [31:0] ins, input logic exec, input logic stall);
    ifu_instruction = ins;
    qed_exec_dup    = exec;
    ifu_stall       = stall;
    @(posedge clk);
    #1;
  endtask

  // Reference model written field-wise: which fields are live, and what each becomes.
  function automatic logic [31:0] model_orig(input logic [31:0] i);
    logic [31:0] m;
    case (i[6:0])
      7'h33:   m = 32'h0108_0800;
      7'h13:   m = 32'h0008_0800;
      7'h37:   m = 32'h0000_0800;
      default: return 32'h0000_0013;
    endcase
    if ((i[11:7] & 5'hF) == 5'd0) return 32'h0000_0013;
    return i & ~m;
  endfunction

  function automatic logic [31:0] model_dup(input logic [31:0] i);
    logic [31:0] r;
    r = i;
    if (i[11:7] != 0) r[11] = 1'b1;
    if ((i[6:0] == 7'h33 || i[6:0] == 7'h13) && i[19:15] != 0) r[19] = 1'b1;
    if (i[6:0] == 7'h33 && i[24:20] != 0) r[24] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [4:0] rd;
    rd = 5'(($urandom_range(0, 1) << 4) | $urandom_range(1, 15));
    return {7'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), rd, 7'h33};
  endfunction

  task automatic issue_orig(input string tag, input logic [31:0] ins, input logic exec);
    logic [31:0] e;
    e = model_orig(ins);
    drive(ins, exec, 1'b0);
    chk({tag, " orig ins"}, qed_instruction, e);
    chk({tag, " vld"}, 32'(qed_vld_out), 32'd1);
    if (e != 32'h0000_0013) begin
      exp_q.push_back(model_dup(e));
      exp_orig++;
    end
  endtask

  task automatic pop_dup(input string tag);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h expected none", tag, qed_instruction);
    end else begin
      checks--;
      e = exp_q.pop_front();
      drive($urandom(), 1'($urandom_range(0, 1)), 1'b0);
      chk({tag, " dup ins"}, qed_instruction, e);
      exp_dup++;
    end
  endtask

  task automatic do_reset();
    reset_x = 1'b0;
    #1;
    chk("rst ins", qed_instruction, 32'h0000_0013);
    chk("rst vld", 32'(qed_vld_out), 32'd0);
    chk_state("rst", 1'b0, 0, 0, 0);
    exp_q.delete();
    exp_orig = 0;
    exp_dup  = 0;
    @(posedge clk);
    #1;
    reset_x = 1'b1;
  endtask

  initial begin
    reset_x = 1'b1;
    ifu_instruction = 32'h0000_0013;
    qed_exec_dup = 1'b0;
    ifu_stall = 1'b0;

    vt[0]  = '{32'h00B5_0533, 1'b0, 1'b0, 32'h00B5_0533, 1'b0, 16'd1, 16'd0, 4'd1};
    vt[1]  = '{32'h0000_0013, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 16'd1, 16'd0, 4'd1};
    vt[2]  = '{32'h0000_0013, 1'b0, 1'b0, 32'h01BD_0D33, 1'b0, 16'd1, 16'd1, 4'd0};
    vt[3]  = '{32'h01CD_8D33, 1'b0, 1'b0, 32'h00C5_8533, 1'b0, 16'd2, 16'd1, 4'd1};
    vt[4]  = '{32'h0070_0293, 1'b1, 1'b0, 32'h0070_0293, 1'b1, 16'd3, 16'd1, 4'd2};
    vt[5]  = '{32'hDEAD_BEEF, 1'b1, 1'b0, 32'h01CD_8D33, 1'b1, 16'd3, 16'd2, 4'd1};
    vt[6]  = '{32'h0000_0013, 1'b0, 1'b0, 32'h0070_0A93, 1'b0, 16'd3, 16'd3, 4'd0};
    vt[7]  = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0013, 1'b0, 16'd3, 16'd3, 4'd0};
    vt[8]  = '{32'h0000_0013, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 16'd3, 16'd3, 4'd0};
    vt[9]  = '{32'h1234_5FB7, 1'b0, 1'b0, 32'h1234_57B7, 1'b0, 16'd4, 16'd3, 4'd1};
    vt[10] = '{32'h0000_0013, 1'b1, 1'b1, 32'h1234_57B7, 1'b0, 16'd4, 16'd3, 4'd1};
    vt[11] = '{32'h0000_0013, 1'b1, 1'b0, 32'h0000_0013, 1'b1, 16'd4, 16'd3, 4'd1};
    vt[12] = '{32'h0000_0013, 1'b0, 1'b0, 32'h1234_5FB7, 1'b0, 16'd4, 16'd4, 4'd0};
    vt[13] = '{32'hFFF9_0893, 1'b1, 1'b0, 32'hFFF1_0093, 1'b1, 16'd5, 16'd4, 4'd1};
    vt[14] = '{32'h0000_0013, 1'b0, 1'b0, 32'hFFF9_0893, 1'b0, 16'd5, 16'd5, 4'd0};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].ins, vt[i].exec, vt[i].stall);
      chk($sformatf("vec%0d ins", i), qed_instruction, vt[i].e_ins);
      chk($sformatf("vec%0d vld", i), 32'(qed_vld_out), 32'd1);
      chk_state($sformatf("vec%0d", i), vt[i].e_mode, vt[i].e_orig, vt[i].e_dup, vt[i].e_cnt);
    end

    // Fill the queue without a request: DUP must be forced at the eighth push.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue_orig($sformatf("fill%0d", i), rand_op(), 1'b0);
      chk_state($sformatf("fill%0d", i), (i == 7), i + 1, 0, i + 1);
    end
    for (int i = 0; i < 8; i++) begin
      pop_dup($sformatf("drain%0d", i));
      chk_state($sformatf("drain%0d", i), (i != 7), 8, i + 1, 7 - i);
    end

    // Stall in DUP with two entries left.
    do_reset();
    issue_orig("stl a", rand_op(), 1'b0);
    issue_orig("stl b", rand_op(), 1'b0);
    issue_orig("stl c", rand_op(), 1'b1);
    pop_dup("stl pop0");
    chk_state("stl pre", 1'b1, 3, 1, 2);
    begin
      logic [31:0] held;
      held = qed_instruction;
      for (int i = 0; i < 3; i++) begin
        drive($urandom(), 1'b1, 1'b1);
        chk($sformatf("stl hold%0d ins", i), qed_instruction, held);
        chk_state($sformatf("stl hold%0d", i), 1'b1, 3, 1, 2);
      end
    end
    pop_dup("stl pop1");
    pop_dup("stl pop2");
    chk_state("stl end", 1'b0, 3, 3, 0);

    // Reset in the middle of DUP with four queued.
    do_reset();
    for (int i = 0; i < 4; i++) issue_orig($sformatf("mid%0d", i), rand_op(), (i == 3));
    chk_state("mid pre", 1'b1, 4, 0, 4);
    do_reset();
    issue_orig("post", 32'h00B5_0533, 1'b1);
    chk_state("post", 1'b1, 1, 0, 1);
    pop_dup("post pop");
    chk("post remap", qed_instruction, 32'h01BD_0D33);
    chk_state("post end", 1'b0, 1, 1, 0);
    chk("sb empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
